// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl
//   Fetch-stage controller: owns the program counter and the IF/ID pipeline
//   register. It applies hold, flush and redirect requests from the hazard
//   unit one posedge after they are presented. It also tracks fetch state
//   (RUN / STALL / SQUASH) and raises a sticky watchdog flag when a stall
//   runs for MAX_STALL consecutive cycles.
//
//   Optional build macro FETCH_PERF_CNT_EN adds two saturating performance
//   counters, stall_count and squash_count, as extra outputs.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned MAX_STALL     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_pc,
  input  logic        hold_ifid,
  input  logic        flush_ifid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state,
  output logic        stall_timeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] squash_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_SQUASH = 2'b10
  } state_e;

  // SQUASH_CYCLES is limited to 0..7, so a 3-bit counter is enough.
  localparam logic [2:0]  SQUASH_INIT = 3'(SQUASH_CYCLES);
  localparam logic [15:0] STALL_LIMIT = 16'(MAX_STALL);

  logic [31:0] pc_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc4_r;
  logic        ifid_valid_r;
  state_e      state_r;
  logic [2:0]  squash_left_r;
  logic [15:0] stall_run_r;
  logic        timeout_r;

  logic        redirect_s;
  logic [31:0] redirect_target_s;
  logic [31:0] pc_plus4_s;
  logic        ifid_bubble_s;
  logic [15:0] stall_run_nxt_s;

  // Redirect selection (branch beats jump), next sequential PC and the
  // next value of the consecutive-stall run counter.
  always_comb begin
    redirect_s    = branch_taken | jump_valid;
    ifid_bubble_s = flush_ifid | redirect_s;
    pc_plus4_s    = pc_r + 32'd4;
    if (branch_taken) begin
      redirect_target_s = branch_target;
    end else begin
      redirect_target_s = jump_target;
    end
    if (hold_pc && !redirect_s) begin
      if (stall_run_r == 16'hFFFF) begin
        stall_run_nxt_s = stall_run_r;
      end else begin
        stall_run_nxt_s = stall_run_r + 16'd1;
      end
    end else begin
      stall_run_nxt_s = 16'h0000;
    end
  end

  // Program counter: a redirect overrides hold_pc; otherwise advance by 4
  // (wrapping modulo 2^32) unless held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (redirect_s) begin
      pc_r <= redirect_target_s;
    end else if (hold_pc) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pc_plus4_s;
    end
  end

  // IF/ID register: bubble on flush/redirect, freeze on hold, else capture
  // the fetched word. Words fetched while squashing are marked invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else if (ifid_bubble_s) begin
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else if (hold_ifid) begin
      ifid_instr_r <= ifid_instr_r;
      ifid_pc4_r   <= ifid_pc4_r;
      ifid_valid_r <= ifid_valid_r;
    end else begin
      ifid_instr_r <= imem_rdata;
      ifid_pc4_r   <= pc_plus4_s;
      ifid_valid_r <= (state_r != ST_SQUASH);
    end
  end

  // Fetch state machine. A redirect is checked first in every state and
  // (re)loads the squash counter; the counter only moves on non-held cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      squash_left_r <= 3'd0;
    end else if (redirect_s) begin
      if (SQUASH_INIT == 3'd0) begin
        state_r       <= ST_RUN;
        squash_left_r <= 3'd0;
      end else begin
        state_r       <= ST_SQUASH;
        squash_left_r <= SQUASH_INIT;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hold_pc) begin
            state_r <= ST_STALL;
          end else begin
            state_r <= ST_RUN;
          end
          squash_left_r <= 3'd0;
        end
        ST_STALL: begin
          if (hold_pc) begin
            state_r <= ST_STALL;
          end else begin
            state_r <= ST_RUN;
          end
          squash_left_r <= 3'd0;
        end
        ST_SQUASH: begin
          if (hold_pc) begin
            state_r       <= ST_SQUASH;
            squash_left_r <= squash_left_r;
          end else if (squash_left_r <= 3'd1) begin
            state_r       <= ST_RUN;
            squash_left_r <= 3'd0;
          end else begin
            state_r       <= ST_SQUASH;
            squash_left_r <= squash_left_r - 3'd1;
          end
        end
        default: begin
          state_r       <= ST_RUN;
          squash_left_r <= 3'd0;
        end
      endcase
    end
  end

  // Livelock watchdog: count consecutive held cycles and latch the timeout
  // flag once the run reaches the limit; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_run_r <= 16'h0000;
      timeout_r   <= 1'b0;
    end else begin
      stall_run_r <= stall_run_nxt_s;
      timeout_r   <= timeout_r | (stall_run_nxt_s >= STALL_LIMIT);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_squash_r;
  logic        squash_write_s;

  // An invalid entry lands in IF/ID on a flush/redirect bubble or on a
  // capture made while squashing.
  always_comb begin
    squash_write_s = ifid_bubble_s | (!hold_ifid && (state_r == ST_SQUASH));
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_r  <= 32'h0000_0000;
      perf_squash_r <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_STALL) && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (squash_write_s && (perf_squash_r != 32'hFFFF_FFFF)) begin
        perf_squash_r <= perf_squash_r + 32'd1;
      end else begin
        perf_squash_r <= perf_squash_r;
      end
    end
  end

  assign stall_count  = perf_stall_r;
  assign squash_count = perf_squash_r;
`endif

  assign imem_addr     = pc_r;
  assign ifid_instr    = ifid_instr_r;
  assign ifid_pc4      = ifid_pc4_r;
  assign ifid_valid    = ifid_valid_r;
  assign fetch_state   = state_r;
  assign stall_timeout = timeout_r;

endmodule
